// File: rtl/addsub_pkg.sv
// Shared constants, state encoding and index-width helper for the sequential
// 64-bit adder/subtractor.
package addsub_pkg;

  localparam int DATA_W      = 64;
  localparam int SLICE_W_DEF = 16;
  localparam int NUM_SLICES  = DATA_W / SLICE_W_DEF;

  // Slice-index width for a given slice width; legal slice widths are 8, 16 and 32.
  function automatic int idx_bits(input int slice_w);
    return $clog2(DATA_W / slice_w);
  endfunction

  localparam int IDX_W = idx_bits(SLICE_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_addsub_64bit_if.sv
// Start/done operand and result bundle between a controller and the
// sequential adder/subtractor.
interface seq_addsub_64bit_if;

  logic                           start;
  logic [addsub_pkg::DATA_W-1:0]  a;
  logic [addsub_pkg::DATA_W-1:0]  b;
  logic                           c_in;
  logic                           sub;
  logic                           busy;
  logic                           done;
  logic [addsub_pkg::DATA_W-1:0]  out;
  logic                           c_out;
  logic                           overflow;

  modport master (
    output start, a, b, c_in, sub,
    input  busy, done, out, c_out, overflow
  );

  modport slave (
    input  start, a, b, c_in, sub,
    output busy, done, out, c_out, overflow
  );

endinterface

// File: rtl/csa_slice.sv
// One carry-select slice: two ripple adders (carry-in 0 and 1) evaluated in
// parallel, with the real carry-in choosing between them.
module csa_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         c_msb_o
);

  logic [W-1:0] sum0, sum1;
  logic         cout0, cout1;
  logic         cmsb0, cmsb1;
  logic         c0, c1;

  // Both ripple chains share the loop; c0/c1 carry the running carry of each.
  always_comb begin
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    sum0  = '0;
    sum1  = '0;
    cmsb0 = 1'b0;
    cmsb1 = 1'b0;
    c0    = 1'b0;
    c1    = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) begin
        cmsb0 = c0;
        cmsb1 = c1;
      end
      sum0[i] = a_i[i] ^ b_i[i] ^ c0;
      c0      = (a_i[i] & b_i[i]) | (c0 & (a_i[i] ^ b_i[i]));
      sum1[i] = a_i[i] ^ b_i[i] ^ c1;
      c1      = (a_i[i] & b_i[i]) | (c1 & (a_i[i] ^ b_i[i]));
    end
    cout0 = c0;
    cout1 = c1;
  end

  assign sum_o   = cin_i ? sum1  : sum0;
  assign cout_o  = cin_i ? cout1 : cout0;
  assign c_msb_o = cin_i ? cmsb1 : cmsb0;

endmodule

// File: rtl/seq_addsub_64bit.sv
// Multi-cycle 64-bit adder/subtractor: one carry-select slice per clock,
// start/done handshake, subtraction as a + ~b + 1.
module seq_addsub_64bit
  import addsub_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  seq_addsub_64bit_if.slave bus
);

  localparam int N_SLICES  = DATA_W / SLICE_W;
  localparam int IDX_BITS  = idx_bits(SLICE_W);
  localparam int SLICE_LOG = $clog2(SLICE_W);
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(N_SLICES - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                carry_q, carry_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                c_out_q, c_out_d;
  logic                ovf_q, ovf_d;

  // Bit offset of the current slice: idx * SLICE_W, built by concatenation.
  logic [IDX_BITS+SLICE_LOG-1:0] lo;
  assign lo = {idx_q, {SLICE_LOG{1'b0}}};

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               slice_cmsb;

  csa_slice #(.W(SLICE_W)) u_slice (
    .a_i     (a_q[lo +: SLICE_W]),
    .b_i     (b_q[lo +: SLICE_W]),
    .cin_i   (carry_q),
    .sum_o   (slice_sum),
    .cout_o  (slice_cout),
    .c_msb_o (slice_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    out_d   = out_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.c_in;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        out_d[lo +: SLICE_W] = slice_sum;
        carry_d              = slice_cout;
        if (idx_q == IDX_LAST) begin
          // The top slice's MSB is bit 63, so its carry-in/out give signed overflow.
          c_out_d = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset clears the datapath registers too, so an aborted run leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      out_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.out      = out_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_seq_addsub_64bit.sv
// Directed-vector bench for seq_addsub_64bit: arithmetic results, latency,
// handshake rules, start-while-busy and reset abort.
module tb_seq_addsub_64bit;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  seq_addsub_64bit_if bus ();

  seq_addsub_64bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, input logic sb);
    bus.start = st;
    bus.a     = av;
    bus.b     = bv;
    bus.c_in  = ci;
    bus.sub   = sb;
  endtask

  // Starts at a falling edge, returns at the falling edge after the done cycle.
  task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                        input logic ci, input logic sb,
                        input logic [63:0] eo, input logic ec, input logic ev);
    int lat;
    drive(1'b1, av, bv, ci, sb);
    @(negedge clk);
    // Scramble operands after acceptance; the operation in flight must not notice.
    drive(1'b0, ~av, {$urandom, $urandom}, ~ci, ~sb);
    lat = 0;
    while (!bus.done && lat < 20) begin
      check({tag, "_busy"}, 64'(bus.busy), 64'd1);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_out"}, bus.out, eo);
    check({tag, "_cout"}, 64'(bus.c_out), 64'(ec));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(ev));
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "_out_hold"}, bus.out, eo);
  endtask

  initial begin
    int lat;
    int ndone;

    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_out", bus.out, 64'd0);
    check("rst_cout", 64'(bus.c_out), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    run_op("add_pat", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("add_pat_cin", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0,
           64'h0, 1'b1, 1'b0);
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub_borrow", 64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_pos", 64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Second start two cycles into the operation must be ignored.
    drive(1'b1, 64'h3, 64'h4, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 64'h3, 64'h4, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 64'h100, 64'h200, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("busy_start_wait", 64'(lat), 64'd2);
    check("busy_start_out", bus.out, 64'h8);
    check("busy_start_cout", 64'(bus.c_out), 64'd0);
    // Start during the done cycle is also ignored.
    drive(1'b1, 64'h10, 64'h20, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    check("done_start_busy", 64'(bus.busy), 64'd0);
    check("done_start_out", bus.out, 64'h8);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("busy_start_extra_done", 64'(ndone), 64'd0);

    // Reset in the second RUN cycle aborts the operation.
    drive(1'b1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    check("abort_run1_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_out", bus.out, 64'd0);
    check("abort_cout", 64'(bus.c_out), 64'd0);
    // Reset and start together: reset wins.
    drive(1'b1, 64'h5, 64'h6, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_vs_start_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    drive(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_out_hold", bus.out, 64'd0);

    run_op("after_abort", 64'h1, 64'h2, 1'b0, 1'b0, 64'h3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
